// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose
//   Hazard and sequencing control for the front end of the 5-stage core.
//   Drives the write enables and bubble-insert (flush) controls of the PC,
//   F/D, D/X and X/M latches for three hazard sources:
//     - load-use: a lw in D/X feeds a register read by the instruction in F/D
//     - taken branch/jump resolved in X: squash the two younger instructions
//     - multi-cycle mul/div in X: hold the front end until the unit answers
//   Owns the mult/div handshake (go pulse, busy wait, timeout abort) and a
//   saturating count of front-end stall cycles.
//
// Parameters
//   MD_TIMEOUT  cycles allowed in MD_WAIT before a forced abort (2..64)
//   CNT_W       width of the stall_cycles statistic counter
//
// Ports
//   clock         in   rising-edge clock shared with all pipeline latches
//   reset         in   synchronous, active-low
//   fd_rs1/rs2    in   source registers of the instruction in F/D
//   fd_uses_rs2   in   F/D instruction actually reads rs2
//   dx_is_load    in   instruction in D/X is a load
//   dx_rd         in   destination register of the instruction in D/X
//   branch_taken  in   X resolves a taken branch/jump this cycle
//   md_start      in   instruction in X is mul/div (level, held while in X)
//   md_ready      in   mult/div result valid (1-cycle pulse)
//   pc_en         out  PC write enable
//   fd_en/dx_en   out  F/D and D/X latch write enables
//   fd_flush      out  F/D loads a nop (always with fd_en=1)
//   dx_flush      out  D/X loads a nop (always with dx_en=1)
//   xm_flush      out  X/M loads a nop
//   md_go         out  1-cycle start pulse to the mult/div unit
//   md_timeout    out  sticky error flag: the mult/div unit never answered
//   stall_cycles  out  saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic             fd_uses_rs2,
    input  logic             dx_is_load,
    input  logic [4:0]       dx_rd,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_en,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_go,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    // Last wait_cnt value at which the unit may still answer normally.
    localparam logic [5:0]       WAIT_LAST = 6'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]       state_q,        state_d;
    logic [5:0]       wait_cnt_q,     wait_cnt_d;
    logic             md_go_q,        md_go_d;
    logic             md_timeout_q,   md_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic             load_use;
    logic             md_ready_eff;
    logic             md_expire;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));

    // A ready seen in the same cycle as go cannot belong to this operation:
    // the unit has not sampled go yet, so that pulse is stale.
    assign md_ready_eff = md_ready && !md_go_q;

    // Final wait cycle with no answer: abort instead of waiting any longer.
    assign md_expire = (wait_cnt_q == WAIT_LAST) && !md_ready_eff;

    // -----------------------------------------------------------------------
    // Next-state and latch-control decode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        fd_flush     = 1'b0;
        dx_en        = 1'b1;
        dx_flush     = 1'b0;
        xm_flush     = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        md_go_d      = 1'b0;
        md_timeout_d = md_timeout_q;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    // Squash the wrong-path instructions in F/D and D/X; the
                    // branch itself moves on, so X/M is not flushed. Any
                    // md_start/load_use belongs to squashed instructions.
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (md_start) begin
                    // Freeze everything up to X; X/M gets a bubble while the
                    // mul/div sits in X waiting for its result.
                    pc_en      = 1'b0;
                    fd_en      = 1'b0;
                    dx_en      = 1'b0;
                    xm_flush   = 1'b1;
                    state_d    = ST_MD_WAIT;
                    md_go_d    = 1'b1;
                    wait_cnt_d = 6'd0;
                end else if (load_use) begin
                    // Hold PC and F/D one cycle; the load advances and a
                    // bubble enters D/X, after which the hazard is re-checked.
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_flush = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                wait_cnt_d = wait_cnt_q + 6'd1;
                if (md_ready_eff) begin
                    // Result is written into X/M; the front end resumes now.
                    state_d = ST_RUN;
                end else if (md_expire) begin
                    // Give up: release the pipeline but drop the missing
                    // result so garbage never reaches X/M.
                    xm_flush     = 1'b1;
                    md_timeout_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_en    = 1'b0;
                    xm_flush = 1'b1;
                end
            end
        endcase
    end

    // Stall statistic: counts every cycle the PC is held, saturating at the
    // top instead of wrapping so a long run never reports a small number.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: reset is synchronous and active-low, so it lives inside the
    // clocked branch; non-blocking assignments keep every flop sampling the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 6'd0;
            md_go_q        <= 1'b0;
            md_timeout_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            md_go_q        <= md_go_d;
            md_timeout_q   <= md_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign md_go        = md_go_q;
    assign md_timeout   = md_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed testbench for pipeline_hazard_ctrl. A main instance uses the
// default parameters; a second instance with a 2-bit stall counter shares
// all inputs so counter saturation is observable in a short run.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1
// time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  fd_rs1;
    logic [4:0]  fd_rs2;
    logic        fd_uses_rs2;
    logic        dx_is_load;
    logic [4:0]  dx_rd;
    logic        branch_taken;
    logic        md_start;
    logic        md_ready;

    logic        pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_flush;
    logic        md_go, md_timeout;
    logic [31:0] stall_cycles;

    logic        s_pc_en, s_fd_en, s_fd_flush, s_dx_en, s_dx_flush, s_xm_flush;
    logic        s_md_go, s_md_timeout;
    logic [1:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .fd_rs1       (fd_rs1),
        .fd_rs2       (fd_rs2),
        .fd_uses_rs2  (fd_uses_rs2),
        .dx_is_load   (dx_is_load),
        .dx_rd        (dx_rd),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .fd_flush     (fd_flush),
        .dx_en        (dx_en),
        .dx_flush     (dx_flush),
        .xm_flush     (xm_flush),
        .md_go        (md_go),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(2)) u_sat (
        .clock        (clock),
        .reset        (reset),
        .fd_rs1       (fd_rs1),
        .fd_rs2       (fd_rs2),
        .fd_uses_rs2  (fd_uses_rs2),
        .dx_is_load   (dx_is_load),
        .dx_rd        (dx_rd),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_ready     (md_ready),
        .pc_en        (s_pc_en),
        .fd_en        (s_fd_en),
        .fd_flush     (s_fd_flush),
        .dx_en        (s_dx_en),
        .dx_flush     (s_dx_flush),
        .xm_flush     (s_xm_flush),
        .md_go        (s_md_go),
        .md_timeout   (s_md_timeout),
        .stall_cycles (s_stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fd_rs1       = 5'd0;
        fd_rs2       = 5'd0;
        fd_uses_rs2  = 1'b0;
        dx_is_load   = 1'b0;
        dx_rd        = 5'd0;
        branch_taken = 1'b0;
        md_start     = 1'b0;
        md_ready     = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // ---- power-on reset -------------------------------------------------
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("por_pc_en",      pc_en,        1);
        check("por_md_go",      md_go,        0);
        check("por_md_timeout", md_timeout,   0);
        check("por_stall",      stall_cycles, 0);
        check("por_fd_flush",   fd_flush,     0);
        check("por_xm_flush",   xm_flush,     0);

        // ---- load-use via rs1 ----------------------------------------------
        tick();
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
        #1;
        check("lu_pc_en",    pc_en,    0);
        check("lu_fd_en",    fd_en,    0);
        check("lu_dx_en",    dx_en,    1);
        check("lu_dx_flush", dx_flush, 1);
        check("lu_fd_flush", fd_flush, 0);
        check("lu_xm_flush", xm_flush, 0);
        tick();
        dx_is_load = 1'b0;
        #1;
        check("lu_release_pc_en", pc_en,        1);
        check("lu_stall_1",       stall_cycles, 1);

        // load into x0 never stalls
        dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs1 = 5'd0;
        #1;
        check("lu_x0_pc_en",    pc_en,    1);
        check("lu_x0_dx_flush", dx_flush, 0);
        tick();
        check("lu_x0_stall", stall_cycles, 1);

        // ---- load-use via rs2 gated by fd_uses_rs2 --------------------------
        dx_is_load = 1'b1; dx_rd = 5'd7; fd_rs1 = 5'd3; fd_rs2 = 5'd7;
        fd_uses_rs2 = 1'b0;
        #1;
        check("rs2_unused_pc_en", pc_en, 1);
        fd_uses_rs2 = 1'b1;
        #1;
        check("rs2_used_pc_en",    pc_en,    0);
        check("rs2_used_dx_flush", dx_flush, 1);
        tick();
        idle_inputs();
        #1;
        check("rs2_stall_2", stall_cycles, 2);
        check("sat_stall_2", s_stall_cycles, 2);

        // ---- taken branch beats load-use and md_start ----------------------
        branch_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
        md_start = 1'b1;
        #1;
        check("br_pc_en",    pc_en,    1);
        check("br_fd_en",    fd_en,    1);
        check("br_fd_flush", fd_flush, 1);
        check("br_dx_en",    dx_en,    1);
        check("br_dx_flush", dx_flush, 1);
        check("br_xm_flush", xm_flush, 0);
        tick();
        idle_inputs();
        #1;
        check("br_no_md_go", md_go,        0);
        check("br_stall",    stall_cycles, 2);
        check("br_run",      pc_en,        1);

        // ---- mul/div, ready 17 cycles after go ------------------------------
        md_start = 1'b1;
        #1;
        check("md_entry_pc_en",    pc_en,    0);
        check("md_entry_dx_en",    dx_en,    0);
        check("md_entry_xm_flush", xm_flush, 1);
        check("md_entry_go",       md_go,    0);
        tick();                                   // wait_cnt = 0, go visible
        md_ready = 1'b1;                          // stale ready, must be ignored
        #1;
        check("md_go_pulse",       md_go, 1);
        check("md_stale_ready",    pc_en, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            md_ready = 1'b0;
            #1;
            check("md_wait_pc_en", pc_en, 0);
            check("md_wait_go",    md_go, 0);
        end
        tick();                                   // wait_cnt = 17
        md_ready = 1'b1;
        #1;
        check("md_rel_pc_en",    pc_en,      1);
        check("md_rel_fd_en",    fd_en,      1);
        check("md_rel_dx_en",    dx_en,      1);
        check("md_rel_xm_flush", xm_flush,   0);
        check("md_rel_timeout",  md_timeout, 0);
        tick();
        idle_inputs();
        #1;
        check("md_done_pc_en",   pc_en,          1);
        check("md_done_stall",   stall_cycles,   20);
        check("md_done_timeout", md_timeout,     0);
        check("sat_stall_max",   s_stall_cycles, 3);

        // ---- mul/div timeout -----------------------------------------------
        md_start = 1'b1;
        tick();                                   // wait_cnt = 0
        #1;
        check("to_go_pulse", md_go, 1);
        for (int k = 1; k <= 38; k++) begin
            tick();
            #1;
            check("to_wait_pc_en", pc_en, 0);
        end
        tick();                                   // wait_cnt = 39
        #1;
        check("to_last_pc_en",    pc_en,      1);
        check("to_last_fd_en",    fd_en,      1);
        check("to_last_dx_en",    dx_en,      1);
        check("to_last_xm_flush", xm_flush,   1);
        check("to_last_timeout",  md_timeout, 0);
        tick();
        md_start = 1'b0;
        #1;
        check("to_flag_set",   md_timeout,   1);
        check("to_run_pc_en",  pc_en,        1);
        check("to_stall",      stall_cycles, 60);
        tick();
        tick();
        check("to_flag_sticky", md_timeout, 1);

        // ---- reset in the middle of MD_WAIT ---------------------------------
        md_start = 1'b1;
        tick();                                   // wait_cnt = 0
        tick();                                   // wait_cnt = 1
        check("rst_pre_pc_en", pc_en, 0);
        reset = 1'b0;
        md_start = 1'b0;
        tick();
        #1;
        check("rst_mid_pc_en", pc_en, 1);
        check("rst_mid_md_go", md_go, 0);
        tick();
        reset = 1'b1;
        #1;
        check("rst_pc_en",      pc_en,          1);
        check("rst_md_go",      md_go,          0);
        check("rst_stall",      stall_cycles,   0);
        check("rst_timeout",    md_timeout,     0);
        check("rst_sat_stall",  s_stall_cycles, 0);
        check("rst_xm_flush",   xm_flush,       0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
